// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
//
// Write-domain pointer and flag controller for an asynchronous FIFO. Drives
// the dual-port memory write address and write enable, keeps the binary and
// Gray write pointers, and derives full, almost-full and fill level against
// the read pointer that is already synchronized into the write domain. A
// sticky overflow flag records writes rejected while full.
//
// Build option:
//   FIFO_AFULL_EN  defined   -> registered almost-full flag with threshold
//                               comparator (AFULL_THRESH words).
//                  undefined -> wafull tied to 0, AFULL_THRESH ignored.
//
// Parameters:
//   ADDRSIZE      memory address bits (>= 2), depth = 2**ADDRSIZE
//   AFULL_THRESH  almost-full threshold in words, 1..2**ADDRSIZE
//
// Ports:
//   wclk      in   write clock
//   wrst_n    in   asynchronous active-low reset
//   winc      in   write request from producer
//   wq2_rptr  in   Gray read pointer, synchronized into wclk
//   wovf_clr  in   clear for the sticky overflow flag
//   waddr     out  memory write address (registered)
//   wclken    out  memory write enable (combinational)
//   wptr      out  Gray write pointer to the read-domain synchronizer
//   wfull     out  FIFO full (registered)
//   wafull    out  almost full (registered, or 0 when disabled)
//   wlevel    out  fill level seen from the write side (registered)
//   wovf      out  sticky overflow flag
// -----------------------------------------------------------------------------
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam logic [ADDRSIZE:0] AfullThresh = (ADDRSIZE + 1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] level_next;
    logic [ADDRSIZE:0] full_cmp;
    logic              full_next;

    // Writes are accepted only while not full; the memory sees this directly.
    assign wclken    = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Gray-to-binary of the synchronized read pointer (XOR prefix from MSB).
    always_comb begin
        rbin           = '0;
        rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Modulo 2**(ADDRSIZE+1) difference; the extra MSB makes 2**ADDRSIZE
    // (full) distinct from 0 (empty).
    assign level_next = wbinnext - rbin;

    // Full when the next write pointer is one lap ahead of the read pointer:
    // in Gray code that means the two MSBs inverted, the rest equal.
    assign full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign full_next = (wgraynext == full_cmp);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            waddr  <= '0;
            wfull  <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            waddr  <= wbinnext[ADDRSIZE-1:0];
            wfull  <= full_next;
            wlevel <= level_next;
        end
    end

    // Sticky overflow: a rejected write sets it and beats a same-edge clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc & wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end

`ifdef FIFO_AFULL_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (level_next >= AfullThresh);
        end
    end
`else
    // Threshold has no effect in this build; keep it referenced.
    logic unused_afull_thresh;
    assign unused_afull_thresh = ^AfullThresh;
    assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
//
// Directed self-checking bench for wptr_full_ctrl with ADDRSIZE=4,
// AFULL_THRESH=12. Inputs change 1 time unit after the rising edge; outputs
// are checked at that point, before new stimulus is applied.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

    localparam int unsigned ADDRSIZE = 4;

`ifdef FIFO_AFULL_EN
    localparam bit AfullOn = 1'b1;
`else
    localparam bit AfullOn = 1'b0;
`endif

    logic                wclk;
    logic                wrst_n;
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wclken;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    int checks   = 0;
    int failures = 0;

    wptr_full_ctrl #(
        .ADDRSIZE    (ADDRSIZE),
        .AFULL_THRESH(12)
    ) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .winc    (winc),
        .wq2_rptr(wq2_rptr),
        .wovf_clr(wovf_clr),
        .waddr   (waddr),
        .wclken  (wclken),
        .wptr    (wptr),
        .wfull   (wfull),
        .wafull  (wafull),
        .wlevel  (wlevel),
        .wovf    (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        logic [ADDRSIZE:0] prev_ptr;
        int                b;

        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = '0;
        wovf_clr = 1'b0;
        #2;
        check_eq("rst_waddr", waddr, 0);
        check_eq("rst_wptr", wptr, 0);
        check_eq("rst_wfull", wfull, 0);
        check_eq("rst_wafull", wafull, 0);
        check_eq("rst_wlevel", wlevel, 0);
        check_eq("rst_wovf", wovf, 0);
        winc = 1'b1;
        #1;
        check_eq("rst_wclken", wclken, 1);
        winc = 1'b0;

        step();
        wrst_n = 1'b1;
        winc   = 1'b1;

        // Fill: 16 writes against an empty read pointer.
        for (int k = 1; k <= 16; k++) begin
            step();
            check_eq("fill_waddr", waddr, k % 16);
            check_eq("fill_wlevel", wlevel, k);
            check_eq("fill_wfull", wfull, (k == 16));
            check_eq("fill_wafull", wafull, AfullOn && (k >= 12));
        end
        check_eq("fill_wptr", wptr, 5'b11000);
        check_eq("full_wclken", wclken, 0);

        // Rejected write while full.
        step();
        check_eq("rej_wovf", wovf, 1);
        check_eq("rej_waddr", waddr, 0);
        check_eq("rej_wptr", wptr, 5'b11000);
        check_eq("rej_wlevel", wlevel, 16);
        winc     = 1'b0;
        wovf_clr = 1'b1;
        step();
        check_eq("clr_wovf", wovf, 0);
        winc = 1'b1;
        step();
        check_eq("setwins_wovf", wovf, 1);
        winc     = 1'b0;
        wovf_clr = 1'b0;

        // Drain release: read pointer advances by one (Gray(1)).
        wq2_rptr = 5'b00001;
        step();
        check_eq("drain_wfull", wfull, 0);
        check_eq("drain_wlevel", wlevel, 15);
        check_eq("drain_wafull", wafull, AfullOn);
        check_eq("drain_wovf_held", wovf, 1);

        // Wrap-around: read pointer at Gray(16), 16 more writes.
        wq2_rptr = 5'b11000;
        winc     = 1'b1;
        prev_ptr = wptr;
        for (int k = 1; k <= 16; k++) begin
            step();
            b = (16 + k) % 32;
            check_eq("wrap_wptr", wptr, b ^ (b >> 1));
            check_eq("wrap_onebit", $countones(prev_ptr ^ wptr), 1);
            check_eq("wrap_waddr", waddr, k % 16);
            check_eq("wrap_wlevel", wlevel, k);
            check_eq("wrap_wfull", wfull, (k == 16));
            prev_ptr = wptr;
        end
        check_eq("wrap_wptr_zero", wptr, 0);

        // Read pointer at binary 23 (Gray 11100) -> 9 words.
        winc     = 1'b0;
        wq2_rptr = 5'b11100;
        step();
        check_eq("pre_rst_wlevel", wlevel, 9);
        check_eq("pre_rst_wfull", wfull, 0);

        // Asynchronous reset mid-cycle.
        #3;
        wrst_n = 1'b0;
        #1;
        check_eq("arst_waddr", waddr, 0);
        check_eq("arst_wptr", wptr, 0);
        check_eq("arst_wfull", wfull, 0);
        check_eq("arst_wafull", wafull, 0);
        check_eq("arst_wlevel", wlevel, 0);
        check_eq("arst_wovf", wovf, 0);

        // Restart from reset with a single write.
        wq2_rptr = '0;
        step();
        wrst_n = 1'b1;
        winc   = 1'b1;
        step();
        winc = 1'b0;
        check_eq("restart_waddr", waddr, 1);
        check_eq("restart_wptr", wptr, 1);
        check_eq("restart_wlevel", wlevel, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
